// File: rtl/dec_pipe.sv
// dec_pipe: parametrised binary-to-N-bit decoder with an elastic valid/ready pipeline.
//
// The input code k is decoded combinationally according to in_mode_i:
//   0 one-hot, 1 thermometer [k:0], 2 inverted one-hot, 3 exclusive thermometer [k-1:0].
// The decoded word then passes through STAGES register slices. STAGES=0 gives a
// purely combinational path.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   in_data_i    binary code k (IN_WIDTH bits)
//   in_mode_i    decode mode, carried with its word
//   in_valid_i   input word valid
//   in_ready_o   input word accepted this cycle
//   out_data_o   decoded word (OUT_WIDTH bits)
//   out_valid_o  output word valid
//   out_ready_i  downstream accepts the output word
//   out_err_o    (DEC_PIPE_ERR_EN only) word was out of range, k >= OUT_WIDTH
//   err_cnt_o    (DEC_PIPE_ERR_EN only) saturating count of out-of-range words delivered
//
// Optional feature macro: DEC_PIPE_ERR_EN.
module dec_pipe #(
    parameter int unsigned IN_WIDTH  = 6,
    parameter int unsigned OUT_WIDTH = 64,
    parameter int unsigned STAGES    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IN_WIDTH-1:0]  in_data_i,
    input  logic [1:0]           in_mode_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [OUT_WIDTH-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
`ifdef DEC_PIPE_ERR_EN
    ,
    output logic                 out_err_o,
    output logic [7:0]           err_cnt_o
`endif
);

    // ------------------------------------------------------------------
    // Combinational decode. Comparing each bit position against k gives the
    // out-of-range behaviour for free: no position reaches k, so one-hot is
    // all zero and the other three modes are all ones.
    // ------------------------------------------------------------------
    int unsigned          k_int;
    logic [OUT_WIDTH-1:0] dec_word;

    assign k_int = 32'(in_data_i);

    always_comb begin
        dec_word = '0;
        for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
            case (in_mode_i)
                2'd0:    dec_word[i] = (i == k_int);
                2'd1:    dec_word[i] = (i <= k_int);
                2'd2:    dec_word[i] = (i != k_int);
                default: dec_word[i] = (i <  k_int);
            endcase
        end
    end

`ifdef DEC_PIPE_ERR_EN
    logic dec_err;
    assign dec_err = (k_int >= OUT_WIDTH);
`endif

    if (STAGES == 0) begin : g_comb
        assign out_valid_o = in_valid_i;
        assign in_ready_o  = out_ready_i;
        assign out_data_o  = dec_word;
`ifdef DEC_PIPE_ERR_EN
        assign out_err_o   = dec_err;
`endif
    end else begin : g_pipe
        logic [STAGES-1:0]    valid_q;
        logic [OUT_WIDTH-1:0] data_q [STAGES];
        // rdy[i]: stage i loads this cycle; rdy[STAGES] is the consumer.
        logic [STAGES:0]      rdy;
        logic [STAGES-1:0]    up_valid;
        logic [OUT_WIDTH-1:0] up_data [STAGES];

        // A stage loads when empty or when its word leaves this same cycle,
        // so readiness ripples back from out_ready_i without a bubble.
        always_comb begin
            rdy[STAGES] = out_ready_i;
            for (int i = STAGES - 1; i >= 0; i--) begin
                rdy[i] = !valid_q[i] || rdy[i+1];
            end
        end

        always_comb begin
            up_valid[0] = in_valid_i;
            up_data[0]  = dec_word;
            for (int i = 1; i < STAGES; i++) begin
                up_valid[i] = valid_q[i-1];
                up_data[i]  = data_q[i-1];
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_q <= '0;
                for (int i = 0; i < STAGES; i++) begin
                    data_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < STAGES; i++) begin
                    if (rdy[i]) begin
                        valid_q[i] <= up_valid[i];
                        // Data only moves with a real word; bubbles leave it alone.
                        if (up_valid[i]) begin
                            data_q[i] <= up_data[i];
                        end
                    end
                end
            end
        end

        assign in_ready_o  = rdy[0];
        assign out_valid_o = valid_q[STAGES-1];
        assign out_data_o  = data_q[STAGES-1];

`ifdef DEC_PIPE_ERR_EN
        logic [STAGES-1:0] err_q;
        logic [STAGES-1:0] up_err;

        always_comb begin
            up_err[0] = dec_err;
            for (int i = 1; i < STAGES; i++) begin
                up_err[i] = err_q[i-1];
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                err_q <= '0;
            end else begin
                for (int i = 0; i < STAGES; i++) begin
                    if (rdy[i] && up_valid[i]) begin
                        err_q[i] <= up_err[i];
                    end
                end
            end
        end

        assign out_err_o = err_q[STAGES-1];
`endif
    end

`ifdef DEC_PIPE_ERR_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else if (out_valid_o && out_ready_i && out_err_o && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_dec_pipe.sv
// Self-checking bench for dec_pipe: a 64-bit/2-stage instance driven through a
// scoreboard, a 40-bit/2-stage instance for out-of-range codes and a 0-stage
// instance for the combinational path.
module tb_dec_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main DUT: IN_WIDTH=6, OUT_WIDTH=64, STAGES=2
    logic [5:0]  in_data  = '0;
    logic [1:0]  in_mode  = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;

    // OUT_WIDTH=40 DUT
    logic [5:0]  in40 = '0;
    logic [1:0]  m40  = '0;
    logic        v40  = 1'b0;
    logic        rdy40;
    logic [39:0] out40;
    logic        ov40;

    // STAGES=0 DUT
    logic [5:0]  in0 = '0;
    logic [1:0]  m0  = '0;
    logic        v0  = 1'b0;
    logic        rdy0;
    logic [63:0] out0;
    logic        ov0;
    logic        r0  = 1'b0;

`ifdef DEC_PIPE_ERR_EN
    logic       err_m, err40, err0;
    logic [7:0] cnt_m, cnt40, cnt0;
`endif

    dec_pipe #(.IN_WIDTH(6), .OUT_WIDTH(64), .STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(in_data), .in_mode_i(in_mode), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready)
`ifdef DEC_PIPE_ERR_EN
        , .out_err_o(err_m), .err_cnt_o(cnt_m)
`endif
    );

    dec_pipe #(.IN_WIDTH(6), .OUT_WIDTH(40), .STAGES(2)) dut40 (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(in40), .in_mode_i(m40), .in_valid_i(v40), .in_ready_o(rdy40),
        .out_data_o(out40), .out_valid_o(ov40), .out_ready_i(1'b1)
`ifdef DEC_PIPE_ERR_EN
        , .out_err_o(err40), .err_cnt_o(cnt40)
`endif
    );

    dec_pipe #(.IN_WIDTH(6), .OUT_WIDTH(64), .STAGES(0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(in0), .in_mode_i(m0), .in_valid_i(v0), .in_ready_o(rdy0),
        .out_data_o(out0), .out_valid_o(ov0), .out_ready_i(r0)
`ifdef DEC_PIPE_ERR_EN
        , .out_err_o(err0), .err_cnt_o(cnt0)
`endif
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          n_out = 0;
    int          cyc = 0;
    int          first_in = -1;
    int          first_out = -1;
    logic [63:0] sb[$];
    logic [63:0] lit_q[$];
    bit          stalled = 1'b0;
    logic [63:0] held = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference decode for a 64-bit output, written with shifts and masks.
    function automatic logic [63:0] model(input int k, input int m);
        logic [64:0] one;
        logic [64:0] t;
        one = 65'd1;
        case (m)
            0:       t = one << k;
            1:       t = (one << (k + 1)) - 65'd1;
            2:       t = ~(one << k);
            default: t = (one << k) - 65'd1;
        endcase
        return t[63:0];
    endfunction

    // One cycle on the main DUT: called just after a negedge with inputs set.
    task automatic tick(output bit acc);
        int occ;
        logic [63:0] e;
        #2;
        occ = sb.size();
        check("in_ready", 64'(in_ready), 64'(!(occ == 2 && !out_ready)));
        if (stalled) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", out_data, held);
        end
        if (out_valid && first_out < 0) first_out = cyc;
        if (out_valid && out_ready) begin
            n_vec++;
            assert (sb.size() > 0) else begin
                n_bad++;
                $error("FAIL extra_word: got %h want none", out_data);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("data", out_data, e);
            end
            n_out++;
        end
        acc = in_valid && in_ready;
        if (acc) begin
            if (first_in < 0) first_in = cyc;
            if (lit_q.size() > 0) sb.push_back(lit_q.pop_front());
            else sb.push_back(model(int'(in_data), int'(in_mode)));
        end
        stalled = out_valid && !out_ready;
        held = out_data;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int n0;
        int idx;
        int step;
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Stream k=0..63, one-hot
        n0 = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data = 6'(i);
            in_mode = 2'd0;
            tick(acc);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick(acc);
        check("t1_latency", 64'(first_out - first_in), 64'd2);
        check("t1_count", 64'(n_out - n0), 64'd64);

        // Mode sweep on k=5, plus exclusive thermometer k=0
        lit_q = '{64'h20, 64'h3F, 64'hFFFF_FFFF_FFFF_FFDF, 64'h1F, 64'h0};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = (i == 4) ? 6'd0 : 6'd5;
            in_mode = (i == 4) ? 2'd3 : 2'(i);
            tick(acc);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick(acc);
        check("t2_drain", 64'(sb.size()), 64'd0);

        // Backpressure, ready pattern 1,0,0,1
        n0 = n_out;
        idx = 0;
        step = 0;
        for (int it = 0; it < 200 && (idx < 10 || sb.size() > 0); it++) begin
            out_ready = pat[step % 4];
            step++;
            in_valid = (idx < 10);
            in_data = 6'(10 + idx);
            in_mode = 2'd0;
            tick(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("t3_sent", 64'(idx), 64'd10);
        check("t3_count", 64'(n_out - n0), 64'd10);
        tick(acc);

        // OUT_WIDTH=40, k=45 out of range
        v40 = 1'b1; in40 = 6'd45; m40 = 2'd0;
        tick(acc);
        m40 = 2'd1;
        tick(acc);
        v40 = 1'b0;
        #1;
        check("w40_valid0", 64'(ov40), 64'd1);
        check("w40_mode0", 64'(out40), 64'd0);
`ifdef DEC_PIPE_ERR_EN
        check("w40_err", 64'(err40), 64'd1);
        check("w40_cnt0", 64'(cnt40), 64'd0);
`endif
        tick(acc);
        #1;
        check("w40_valid1", 64'(ov40), 64'd1);
        check("w40_mode1", 64'(out40), 64'hFF_FFFF_FFFF);
`ifdef DEC_PIPE_ERR_EN
        check("w40_cnt1", 64'(cnt40), 64'd1);
`endif
        tick(acc);
`ifdef DEC_PIPE_ERR_EN
        v40 = 1'b1;
        for (int i = 0; i < 300; i++) tick(acc);
        v40 = 1'b0;
        for (int i = 0; i < 3; i++) tick(acc);
        check("w40_sat", 64'(cnt40), 64'd255);
`endif

        // Reset with two words in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 6'd1; in_mode = 2'd0;
        tick(acc);
        in_data = 6'd2;
        tick(acc);
        in_valid = 1'b0;
        #2;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_data", out_data, 64'd0);
        check("async_ready", 64'(in_ready), 64'd1);
        sb.delete();
        stalled = 1'b0;
        #1;
        rst = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        n0 = n_out;
        first_in = -1;
        first_out = -1;
        in_valid = 1'b1; in_data = 6'd3; in_mode = 2'd0;
        lit_q = '{64'h8};
        tick(acc);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick(acc);
        check("rst_latency", 64'(first_out - first_in), 64'd2);
        check("rst_single", 64'(n_out - n0), 64'd1);

        // STAGES=0 combinational path
        v0 = 1'b1; in0 = 6'd63; m0 = 2'd0; r0 = 1'b0;
        #1;
        check("s0_data", out0, 64'h8000_0000_0000_0000);
        check("s0_valid", 64'(ov0), 64'd1);
        check("s0_ready_lo", 64'(rdy0), 64'd0);
        r0 = 1'b1;
        #1;
        check("s0_ready_hi", 64'(rdy0), 64'd1);
        in0 = 6'd7; m0 = 2'd1;
        #1;
        check("s0_thermo", out0, 64'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dec_pipe.md
Name: dec_pipe

Overview:
- Parametrised binary-to-N-bit decoder; successor to the fixed 6-to-64 decoder.
- Adds configurable input and output width, a selectable decode mode, and an elastic valid/ready pipeline of configurable depth with full-throughput backpressure.
- Sits between index-producing logic (address/channel selectors) and one-hot/mask consumers.

Parameters:
- IN_WIDTH, 6, width of the binary code input (1..8).
- OUT_WIDTH, 64, width of the decoded output; must be >= 1 and <= 2**IN_WIDTH.
- STAGES, 1, register stages between input and output (0..4); 0 = purely combinational path.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- in_data_i  in  IN_WIDTH  binary code k.
- in_mode_i  in  2  decode mode, travels with its data word.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  block accepts the input word this cycle.
- out_data_o  out  OUT_WIDTH  decoded word.
- out_valid_o  out  1  output word valid.
- out_ready_i  in  1  downstream accepts the output word.

Behaviour:
- Interface: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Decode is combinational at the input, then carried through STAGES registers. Let k = in_data_i.
- Mode 0, one-hot: only bit k set.
- Mode 1, thermometer: bits [k:0] set.
- Mode 2, inverted one-hot: all bits set except bit k.
- Mode 3, exclusive thermometer: bits [k-1:0] set; k=0 gives all zero.
- Out-of-range (k >= OUT_WIDTH): one-hot gives all zero; thermometer gives all ones; inverted gives all ones; exclusive thermometer gives all ones.
- Pipeline: each stage holds a valid bit and a data word.
  - Stage n loads when it is empty, or when stage n+1 (or the consumer, for the last stage) takes its word in the same cycle.
  - Full throughput: one word per cycle when out_ready_i stays high.
  - in_ready_o = stage-0 load condition. It is combinational from out_ready_i through the chain; no skid buffer.
- Latency: STAGES cycles from accepted input to out_valid_o with no stall.
- STAGES=0: out_valid_o = in_valid_i, in_ready_o = out_ready_i, out_data_o = decode(in_data_i).
- Handshake rules:
  - A transfer occurs on a rising edge with valid & ready both high.
  - While out_valid_o=1 and out_ready_i=0, out_data_o is held stable. Once asserted, valid is not withdrawn until the transfer.
  - in_data_i and in_mode_i are sampled only on an input transfer.
- Simultaneous events: with a full pipeline and out_ready_i=1, output transfer and input acceptance happen in the same cycle and no bubble is inserted.
- Reset (asynchronous, including mid-operation):
  - All stage valid bits and data words clear to 0 immediately.
  - Outputs after reset: out_valid_o=0, out_data_o=0. in_ready_o=1 for STAGES>0.
  - In-flight words are discarded.
- Order preserved; no word dropped or duplicated.

Optional Feature:
- Macro DEC_PIPE_ERR_EN.
- When defined, two extra outputs exist:
  - out_err_o (1 bit): travels with the word, set when k >= OUT_WIDTH.
  - err_cnt_o (8 bits): saturating count of out-of-range words transferred at the output; sticks at 255; cleared by rst_i.
- When undefined: ports and logic are absent; out-of-range words are decoded per mode with no indication.

Test Plan (IN_WIDTH=6, OUT_WIDTH=64, STAGES=2 unless noted):
- Stream k=0..63 in mode 0, out_ready_i=1. Required:
  - out_valid_o rises 2 cycles after the first input.
  - 64 consecutive words equal 1<<k.
  - in_ready_o stays 1 throughout.
- Mode sweep on k=5. Required:
  - mode 0 -> 0x20.
  - mode 1 -> 0x3F.
  - mode 2 -> 0xFFFF_FFFF_FFFF_FFDF.
  - mode 3 -> 0x1F.
  - Also mode 3, k=0 -> 0.
- Backpressure: stream k=10..19 while out_ready_i toggles 1,0,0,1 repeatedly. Required:
  - out_data_o is stable during stalls.
  - Exactly 10 words appear in order.
  - in_ready_o=0 only when both stages are full and out_ready_i=0.
- OUT_WIDTH=40, k=45. Required:
  - mode 0 -> 0.
  - mode 1 -> 0xFF_FFFF_FFFF.
  - With DEC_PIPE_ERR_EN: out_err_o=1 and err_cnt_o increments to 1; 300 such words -> err_cnt_o=255.
- Assert rst_i mid-stream with 2 words in flight. Required:
  - out_valid_o=0 and out_data_o=0 immediately, with no clock edge needed.
  - After release, the next word k=3 appears alone 2 cycles later as 0x8.
- STAGES=0, k=63, mode 0. Required:
  - out_data_o=0x8000_0000_0000_0000 in the same cycle.
  - in_ready_o follows out_ready_i.
